// File: rtl/accel_run_ctrl.sv
// accel_run_ctrl: run controller sitting between a host and one accelerator.
//   - Forwards host slave-RAM requests to the accelerator while idle, and
//     tracks outstanding reads so a run never starts with reads in flight.
//   - Sequences start_port / done_port, counts run cycles, and reports
//     OK / ABORT / TIMEOUT status with the latched cycle count.
// Build option: define ACCEL_RUN_CTRL_TIMEOUT_EN to enable the run-cycle
//   timeout comparator (timeout_limit, status 01). Undefined: no timeout.
// Ports:
//   clock, reset (sync, active-low)
//   host_go, host_abort, timeout_limit          run control from host
//   host_oe/we/addr/wdata/size -> S_*_ram        slave-RAM request path
//   Sout_Rdata_ram/Sout_DataRdy -> host_rdata/rdy read return path
//   start_port, done_port, acc_reset             accelerator handshake/reset
//   host_grant, busy, result_valid, result_status, cycle_count  status
module accel_run_ctrl #(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned RD_MAX = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_go,
    input  logic              host_abort,
    input  logic [CNT_W-1:0]  timeout_limit,
    input  logic [1:0]        host_oe,
    input  logic [1:0]        host_we,
    input  logic [15:0]       host_addr,
    input  logic [127:0]      host_wdata,
    input  logic [13:0]       host_size,
    output logic [1:0]        S_oe_ram,
    output logic [1:0]        S_we_ram,
    output logic [15:0]       S_addr_ram,
    output logic [127:0]      S_Wdata_ram,
    output logic [13:0]       S_data_ram_size,
    input  logic [127:0]      Sout_Rdata_ram,
    input  logic [1:0]        Sout_DataRdy,
    output logic [127:0]      host_rdata,
    output logic [1:0]        host_rdy,
    output logic              start_port,
    input  logic              done_port,
    output logic              acc_reset,
    output logic              host_grant,
    output logic              busy,
    output logic              result_valid,
    output logic [1:0]        result_status,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int unsigned RD_W = (RD_MAX < 2) ? 1 : $clog2(RD_MAX + 1);
    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_TIMEOUT = 2'b01;
    localparam logic [1:0] STAT_ABORT   = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [CNT_W-1:0]  count_d;
    logic [1:0]        status_d;
    logic [RD_W-1:0]   rd_cnt;
    logic              grant, abort_pulse, timeout_hit;
    logic              rd_room, rd_inc, rd_dec;

    // Timeout comparator; a zero limit means unlimited.
`ifdef ACCEL_RUN_CTRL_TIMEOUT_EN
    assign timeout_hit = (timeout_limit != '0) && (cnt == timeout_limit);
`else
    logic unused_timeout_limit;
    assign unused_timeout_limit = ^timeout_limit;
    assign timeout_hit = 1'b0;
`endif

    // Slave-RAM path is owned by the host only while idle; reads beyond
    // RD_MAX in flight are dropped rather than forwarded.
    assign rd_room         = rd_cnt < RD_W'(RD_MAX);
    assign S_oe_ram        = (grant && rd_room) ? host_oe : 2'b00;
    assign S_we_ram        = grant ? host_we     : 2'b00;
    assign S_addr_ram      = grant ? host_addr   : 16'h0;
    assign S_Wdata_ram     = grant ? host_wdata  : 128'h0;
    assign S_data_ram_size = grant ? host_size   : 14'h0;
    assign host_rdata      = Sout_Rdata_ram;
    assign host_rdy        = Sout_DataRdy;

    assign rd_inc = S_oe_ram != 2'b00;
    assign rd_dec = (Sout_DataRdy != 2'b00) && (rd_cnt != '0);

    // Outstanding-read tracker.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_cnt <= '0;
        end else if (rd_inc && !rd_dec) begin
            rd_cnt <= rd_cnt + RD_W'(1);
        end else if (!rd_inc && rd_dec) begin
            rd_cnt <= rd_cnt - RD_W'(1);
        end
    end

    // State, run counter and result registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            result_status <= STAT_OK;
            cycle_count   <= '0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            result_status <= status_d;
            cycle_count   <= count_d;
        end
    end

    // Next-state and decode; done beats abort beats timeout in RUN.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        status_d     = result_status;
        count_d      = cycle_count;
        grant        = 1'b0;
        start_port   = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        abort_pulse  = 1'b0;
        case (state)
            ST_IDLE: begin
                grant = 1'b1;
                if (host_go && (rd_cnt == '0) && (host_oe == 2'b00) &&
                    (host_we == 2'b00)) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                busy       = 1'b1;
                start_port = 1'b1;
                cnt_d      = CNT_W'(1);
                status_d   = STAT_OK;
                count_d    = '0;
                if (done_port) begin
                    count_d = CNT_W'(1);
                    state_d = ST_REPORT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                cnt_d = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                if (done_port) begin
                    status_d = STAT_OK;
                    count_d  = cnt;
                    state_d  = ST_REPORT;
                end else if (host_abort) begin
                    status_d    = STAT_ABORT;
                    count_d     = cnt;
                    abort_pulse = 1'b1;
                    state_d     = ST_REPORT;
                end else if (timeout_hit) begin
                    status_d    = STAT_TIMEOUT;
                    count_d     = cnt;
                    abort_pulse = 1'b1;
                    state_d     = ST_REPORT;
                end
            end
            ST_REPORT: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign host_grant = grant;
    assign acc_reset  = reset & ~abort_pulse;

endmodule

// File: tb/tb_accel_run_ctrl.sv
module tb_accel_run_ctrl;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned RD_MAX = 3;

    typedef struct packed {
        logic [1:0]       status;
        logic [CNT_W-1:0] count;
    } exp_t;

    logic              clock;
    logic              reset;
    logic              host_go, host_abort;
    logic [CNT_W-1:0]  timeout_limit;
    logic [1:0]        host_oe, host_we;
    logic [15:0]       host_addr;
    logic [127:0]      host_wdata;
    logic [13:0]       host_size;
    logic [1:0]        S_oe_ram, S_we_ram;
    logic [15:0]       S_addr_ram;
    logic [127:0]      S_Wdata_ram;
    logic [13:0]       S_data_ram_size;
    logic [127:0]      Sout_Rdata_ram, host_rdata;
    logic [1:0]        Sout_DataRdy, host_rdy;
    logic              start_port, done_port, acc_reset;
    logic              host_grant, busy, result_valid;
    logic [1:0]        result_status;
    logic [CNT_W-1:0]  cycle_count;

    exp_t          exp_q[$];
    logic [127:0]  rd_q[$];
    int            errors = 0;
    int            checks = 0;

    accel_run_ctrl #(.CNT_W(CNT_W), .RD_MAX(RD_MAX)) dut (
        .clock(clock), .reset(reset),
        .host_go(host_go), .host_abort(host_abort), .timeout_limit(timeout_limit),
        .host_oe(host_oe), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_size(host_size),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
        .host_rdata(host_rdata), .host_rdy(host_rdy),
        .start_port(start_port), .done_port(done_port), .acc_reset(acc_reset),
        .host_grant(host_grant), .busy(busy), .result_valid(result_valid),
        .result_status(result_status), .cycle_count(cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clock);
    endtask

    // Raise host_go until start_port is seen (bounded); drops go in START.
    task automatic launch(output bit seen);
        seen = 1'b0;
        host_go = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(); #1;
            if (start_port) begin
                seen = 1'b1;
                host_go = 1'b0;
            end
        end
        host_go = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL launch: start_port never rose within 20 cycles");
        end
    endtask

    // Check the REPORT cycle against the head of the scoreboard.
    task automatic check_report(input string name);
        exp_t e;
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: result_valid=%b required 1", name, result_valid);
        end
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_sb: scoreboard empty at report", name);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (result_status !== e.status) begin
                errors++;
                $display("FAIL %s_status: got %b required %b", name, result_status, e.status);
            end
            checks++;
            if (cycle_count !== e.count) begin
                errors++;
                $display("FAIL %s_count: got %0d required %0d", name, cycle_count, e.count);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step(); #1;
        checks++;
        if (host_grant !== 1'b1 || busy !== 1'b0 || start_port !== 1'b0 ||
            result_valid !== 1'b0 || result_status !== 2'b00 ||
            cycle_count !== '0 || acc_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: grant=%b busy=%b start=%b rv=%b st=%b cnt=%0d accrst=%b required 1 0 0 0 00 0 0",
                     host_grant, busy, start_port, result_valid, result_status, cycle_count, acc_reset);
        end
        reset = 1'b1;
        step(); #1;
        checks++;
        if (acc_reset !== 1'b1 || host_grant !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: acc_reset=%b grant=%b required 1 1", acc_reset, host_grant);
        end
    endtask

    task automatic test_done_after_10();
        bit seen;
        int bad;
        exp_q.push_back({2'b00, CNT_W'(11)});
        launch(seen);
        bad = 0;
        for (int k = 1; k <= 10; k++) begin
            step(); #1;
            if (start_port !== 1'b0 || busy !== 1'b1 || result_valid !== 1'b0 ||
                host_grant !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL run10_phase: %0d bad RUN cycles required 0 (start one cycle, busy, no grant)", bad);
        end
        step(); done_port = 1'b1;
        step(); done_port = 1'b0; #1;
        check_report("run10");
        step(); #1;
        checks++;
        if (result_valid !== 1'b0 || host_grant !== 1'b1 || busy !== 1'b0 ||
            cycle_count !== CNT_W'(11)) begin
            errors++;
            $display("FAIL run10_hold: rv=%b grant=%b busy=%b cnt=%0d required 0 1 0 11",
                     result_valid, host_grant, busy, cycle_count);
        end
    endtask

    task automatic test_done_in_start();
        bit seen;
        exp_q.push_back({2'b00, CNT_W'(1)});
        launch(seen);
        done_port = 1'b1;
        step(); done_port = 1'b0; #1;
        check_report("done_start");
    endtask

    task automatic test_timeout();
        bit seen, found;
        int lows;
`ifdef ACCEL_RUN_CTRL_TIMEOUT_EN
        timeout_limit = CNT_W'(5);
        exp_q.push_back({2'b01, CNT_W'(5)});
        launch(seen);
        lows = 0; found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(); #1;
            if (acc_reset === 1'b0) lows++;
            if (result_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (lows != 1) begin
            errors++;
            $display("FAIL timeout_accrst: acc_reset low %0d cycles required 1", lows);
        end
        if (found) check_report("timeout");
        else begin
            checks++; errors++;
            $display("FAIL timeout_report: no result_valid within 30 cycles");
        end
        timeout_limit = '0;
`else
        // Without the timeout build the limit must have no effect.
        timeout_limit = CNT_W'(5);
        exp_q.push_back({2'b10, CNT_W'(13)});
        launch(seen);
        lows = 0; found = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step(); #1;
            if (acc_reset === 1'b0) lows++;
            if (result_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (lows != 0 || found) begin
            errors++;
            $display("FAIL notimeout: acc_reset lows=%0d early_report=%b required 0 0", lows, found);
        end
        step(); host_abort = 1'b1; #1;
        checks++;
        if (acc_reset !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: acc_reset=%b required 0", acc_reset);
        end
        step(); host_abort = 1'b0; #1;
        check_report("abort");
        checks++;
        if (acc_reset !== 1'b1) begin
            errors++;
            $display("FAIL abort_release: acc_reset=%b required 1", acc_reset);
        end
        timeout_limit = '0;
`endif
    endtask

    task automatic test_abort_and_done();
        bit seen;
        exp_q.push_back({2'b00, CNT_W'(4)});
        launch(seen);
        repeat (3) step();
        step(); done_port = 1'b1; host_abort = 1'b1; #1;
        checks++;
        if (acc_reset !== 1'b1) begin
            errors++;
            $display("FAIL abort_done_accrst: acc_reset=%b required 1", acc_reset);
        end
        step(); done_port = 1'b0; host_abort = 1'b0; #1;
        check_report("abort_done");
    endtask

    task automatic test_read_defer();
        bit seen;
        int early;
        logic [127:0] d;
        step();
        host_oe = 2'b01; host_addr = 16'h1234; host_size = 14'h0010;
        rd_q.push_back(128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5);
        #1;
        checks++;
        if (S_oe_ram !== 2'b01 || S_addr_ram !== 16'h1234 || S_data_ram_size !== 14'h0010) begin
            errors++;
            $display("FAIL rd_forward: oe=%b addr=%h size=%h required 01 1234 0010",
                     S_oe_ram, S_addr_ram, S_data_ram_size);
        end
        step(); host_oe = 2'b00; host_go = 1'b1; #1;
        early = (start_port === 1'b1) ? 1 : 0;
        step(); #1;
        if (start_port === 1'b1) early++;
        step();
        d = rd_q.pop_front();
        Sout_DataRdy = 2'b01; Sout_Rdata_ram = d; #1;
        if (start_port === 1'b1) early++;
        checks++;
        if (host_rdy !== 2'b01 || host_rdata !== d) begin
            errors++;
            $display("FAIL rd_return: rdy=%b data=%h required 01 %h", host_rdy, host_rdata, d);
        end
        step(); Sout_DataRdy = 2'b00; Sout_Rdata_ram = '0; #1;
        if (start_port === 1'b1) early++;
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL rd_defer: start_port rose %0d cycles early required 0", early);
        end
        step(); #1;
        seen = (start_port === 1'b1);
        host_go = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rd_start: start_port=%b required 1", start_port);
        end
        host_oe = 2'b11; #1;
        checks++;
        if (S_oe_ram !== 2'b00 || S_addr_ram !== 16'h0 || host_grant !== 1'b0) begin
            errors++;
            $display("FAIL rd_block: oe=%b addr=%h grant=%b required 00 0000 0",
                     S_oe_ram, S_addr_ram, host_grant);
        end
        host_oe = 2'b00;
        exp_q.push_back({2'b00, CNT_W'(1)});
        done_port = 1'b1;
        step(); done_port = 1'b0; #1;
        check_report("rd_run");
    endtask

    task automatic test_rd_saturate();
        bit seen;
        step();
        for (int r = 0; r < 4; r++) begin
            host_oe = 2'b10; #1;
            if (r == 3) begin
                checks++;
                if (S_oe_ram !== 2'b00) begin
                    errors++;
                    $display("FAIL rd_sat_drop: oe=%b required 00", S_oe_ram);
                end
            end
            step();
        end
        host_oe = 2'b00; host_go = 1'b1;
        for (int r = 0; r < 3; r++) begin
            Sout_DataRdy = 2'b10; #1;
            checks++;
            if (start_port !== 1'b0) begin
                errors++;
                $display("FAIL rd_sat_wait%0d: start_port=%b required 0", r, start_port);
            end
            step();
        end
        Sout_DataRdy = 2'b00; #1;
        checks++;
        if (start_port !== 1'b0) begin
            errors++;
            $display("FAIL rd_sat_last: start_port=%b required 0", start_port);
        end
        step(); #1;
        seen = (start_port === 1'b1);
        host_go = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rd_sat_start: start_port=%b required 1", start_port);
        end
        exp_q.push_back({2'b00, CNT_W'(1)});
        done_port = 1'b1;
        step(); done_port = 1'b0; #1;
        check_report("rd_sat_run");
    endtask

    task automatic test_back_to_back();
        bit seen;
        int n;
        for (int r = 0; r < 2; r++) begin
            n = (r == 0) ? 2 : 5;
            exp_q.push_back({2'b00, CNT_W'(n)});
            launch(seen);
            repeat (n - 1) step();
            step(); done_port = 1'b1;
            step(); done_port = 1'b0; #1;
            check_report((r == 0) ? "b2b_a" : "b2b_b");
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        int rv;
        launch(seen);
        repeat (3) step();
        step(); reset = 1'b0; #1;
        checks++;
        if (acc_reset !== 1'b0) begin
            errors++;
            $display("FAIL midrst_accrst: acc_reset=%b required 0", acc_reset);
        end
        step(); reset = 1'b1; #1;
        checks++;
        if (host_grant !== 1'b1 || busy !== 1'b0 || start_port !== 1'b0 ||
            result_valid !== 1'b0 || cycle_count !== '0 || result_status !== 2'b00) begin
            errors++;
            $display("FAIL midrst_state: grant=%b busy=%b start=%b rv=%b cnt=%0d st=%b required 1 0 0 0 0 00",
                     host_grant, busy, start_port, result_valid, cycle_count, result_status);
        end
        rv = 0;
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            if (result_valid === 1'b1 || start_port === 1'b1) rv++;
        end
        checks++;
        if (rv != 0) begin
            errors++;
            $display("FAIL midrst_quiet: %0d cycles with rv/start required 0", rv);
        end
    endtask

    initial begin
        reset = 1'b0; host_go = 1'b0; host_abort = 1'b0; timeout_limit = '0;
        host_oe = 2'b00; host_we = 2'b00; host_addr = '0; host_wdata = '0; host_size = '0;
        Sout_Rdata_ram = '0; Sout_DataRdy = 2'b00; done_port = 1'b0;
        test_reset();
        test_done_after_10();
        test_done_in_start();
        test_timeout();
        test_abort_and_done();
        test_read_defer();
        test_rd_saturate();
        test_back_to_back();
        test_reset_mid_run();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d results outstanding required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
